// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared 1 us prescaler and period counter, per-channel clamp/shadow/slew lanes.
// Optional per-channel command timeout back to centre when SERVO_FAILSAFE_EN is defined.

module servo_pwm_lane #(
    parameter int VAL_W       = 11,
    parameter int CNT_W       = 15,
    parameter int CENTER_US   = 1500,
    parameter int SLEW_STEP   = 10,
    parameter int TIMEOUT_PER = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic             wr,
    input  logic [VAL_W-1:0] wr_val,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm,
    output logic             at_target
);
    localparam int CW = (CNT_W > VAL_W) ? CNT_W : VAL_W;
    localparam logic [VAL_W-1:0] CENTER = VAL_W'(CENTER_US);
    localparam logic [VAL_W:0]   STEP   = (VAL_W+1)'(SLEW_STEP);

    if (TIMEOUT_PER < 1 || SLEW_STEP < 0) begin : g_bad_cfg
        $error("servo_pwm_lane: TIMEOUT_PER must be >= 1 and SLEW_STEP >= 0");
    end

    logic [VAL_W-1:0] shadow, target, active, next_active;
    logic [VAL_W:0]   diff;
    logic             expire;

    // Step toward shadow by at most STEP; the extra diff bit keeps the magnitude unsigned-safe.
    always_comb begin
        next_active = shadow;
        diff        = '0;
        if (SLEW_STEP != 0) begin
            if (shadow >= active) begin
                diff = {1'b0, shadow} - {1'b0, active};
                if (diff > STEP) next_active = active + VAL_W'(SLEW_STEP);
            end else begin
                diff = {1'b0, active} - {1'b0, shadow};
                if (diff > STEP) next_active = active - VAL_W'(SLEW_STEP);
            end
        end
    end

`ifdef SERVO_FAILSAFE_EN
    localparam int TO_W = $clog2(TIMEOUT_PER + 1);
    logic [TO_W-1:0] idle;

    assign expire = boundary && (idle == TO_W'(TIMEOUT_PER - 1));

    // Counts silent periods; saturates so the centre reload fires once per silence.
    always_ff @(posedge clk) begin
        if (!rst)                                         idle <= '0;
        else if (wr)                                      idle <= '0;
        else if (boundary && idle != TO_W'(TIMEOUT_PER))  idle <= idle + 1'b1;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow    <= CENTER;
            target    <= CENTER;
            active    <= CENTER;
            pwm       <= 1'b0;
            at_target <= 1'b1;
        end else begin
            // wr never coincides with expire: commands are refused on the boundary cycle.
            if (wr)          shadow <= wr_val;
            else if (expire) shadow <= CENTER;
            if (boundary) begin
                target <= shadow;
                active <= next_active;
            end
            pwm       <= CW'(cnt) < CW'(active);
            at_target <= (active == target);
        end
    end
endmodule

module servo_pwm_multi #(
    parameter int NUM_CH      = 4,
    parameter int VAL_W       = 11,
    parameter int PRESC       = 100,
    parameter int PERIOD_US   = 20000,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000,
    parameter int CENTER_US   = 1500,
    parameter int SLEW_STEP   = 10,
    parameter int TIMEOUT_PER = 50
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cmd_valid,
    output logic                                         cmd_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cmd_ch,
    input  logic [VAL_W-1:0]                             cmd_val,
    output logic [NUM_CH-1:0]                            pwm,
    output logic [NUM_CH-1:0]                            at_target,
    output logic                                         period_start
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(PERIOD_US);
    localparam int PS_W  = (PRESC > 1) ? $clog2(PRESC) : 1;

    if (NUM_CH < 1 || NUM_CH > 8 || MIN_US > MAX_US) begin : g_bad_cfg
        $error("servo_pwm_multi: NUM_CH must be 1..8 and MIN_US <= MAX_US");
    end

    logic [PS_W-1:0]  presc;
    logic [CNT_W-1:0] cnt;
    logic             tick, boundary, xfer;
    logic [VAL_W-1:0] clamped;

    assign tick      = (presc == PS_W'(PRESC - 1));
    assign boundary  = tick && (cnt == CNT_W'(PERIOD_US - 1));
    assign cmd_ready = ~boundary;
    assign xfer      = cmd_valid && cmd_ready;

    always_comb begin
        clamped = cmd_val;
        if (cmd_val < VAL_W'(MIN_US))      clamped = VAL_W'(MIN_US);
        else if (cmd_val > VAL_W'(MAX_US)) clamped = VAL_W'(MAX_US);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc        <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + 1'b1;
            period_start <= boundary;
            if (boundary)  cnt <= '0;
            else if (tick) cnt <= cnt + 1'b1;
        end
    end

    // Channel numbers >= NUM_CH match no lane, so such commands are accepted and dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        servo_pwm_lane #(
            .VAL_W       (VAL_W),
            .CNT_W       (CNT_W),
            .CENTER_US   (CENTER_US),
            .SLEW_STEP   (SLEW_STEP),
            .TIMEOUT_PER (TIMEOUT_PER)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .boundary  (boundary),
            .wr        (xfer && (cmd_ch == CH_W'(i))),
            .wr_val    (clamped),
            .cnt       (cnt),
            .pwm       (pwm[i]),
            .at_target (at_target[i])
        );
    end
endmodule
